// File: rtl/hpu_qualified_rx_fifo_pkg.sv
// Shared helpers for the qualified receive FIFO: elaboration-time sizing checks.
package hpu_qualified_rx_fifo_pkg;

  // Every word still in flight when stop is first seen must fit behind the stop threshold.
  function automatic bit rtt_fits(input int depth, input int rtt);
    return depth >= rtt + 2;
  endfunction

endpackage

// File: rtl/hpu_qualified_rx_ram.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
module hpu_qualified_rx_ram
  import hpu_qualified_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hpu_qualified_rx_fifo.sv
// Receive FIFO for a valid-only stream; raises a registered stop early enough that
// every word the producer may still send after seeing it lands without overflow.
module hpu_qualified_rx_fifo
  import hpu_qualified_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int RTT        = 2,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  s_rst_n,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_stop,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  error_ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (!rtt_fits(DEPTH, RTT)) begin : g_depth_check
    $error("hpu_qualified_rx_fifo: DEPTH must be at least RTT+2");
  end

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             full;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] occ_next;
  logic             stop_next;

  assign out_vld = (occupancy != '0);
  assign full    = (occupancy == CNT_W'(DEPTH));
  assign pop     = out_vld & out_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push    = in_vld & (~full | pop);

  always_comb begin
    occ_next = occupancy;
    case ({push, pop})
      2'b10:   occ_next = occupancy + 1'b1;
      2'b01:   occ_next = occupancy - 1'b1;
      default: occ_next = occupancy;
    endcase
  end

  assign stop_next = (CNT_W'(DEPTH) - occ_next) <= CNT_W'(RTT);

  // Control state; storage contents are deliberately left unreset.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      occupancy <= '0;
      out_stop  <= 1'b1;
      error_ovf <= 1'b0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      occupancy <= occ_next;
      out_stop  <= stop_next;
      if (in_vld & full & ~pop) error_ovf <= 1'b1;
    end
  end

  hpu_qualified_rx_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata (in_data),
    .raddr (rptr),
    .rdata (out_data)
  );

endmodule
